// File: rtl/sna_axi_request_issuer.sv
`default_nettype none
// ============================================================================
// Module   : sna_axi_request_issuer
// Brief    : Buffers SNA NoC requests and issues them as AXI4-Lite AR or AW+W
//            transactions, tracking each request's source in a tag FIFO.
//            Optional macro SNA_REQ_WSTRB_EN adds req_strb / wstrb ports.
// Revision : 1.0 - initial release
// ============================================================================
module sna_axi_request_issuer #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int NODE_ADDR_WIDTH = 4,
    parameter int NUM_VC          = 8,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [ADDR_WIDTH-1:0]      req_addr,
    input  logic [DATA_WIDTH-1:0]      req_data,
    input  logic                       req_read,
    input  logic [NODE_ADDR_WIDTH-1:0] req_src,
    input  logic                       req_valid,
`ifdef SNA_REQ_WSTRB_EN
    input  logic [DATA_WIDTH/8-1:0]    req_strb,
`endif
    output logic [NUM_VC-1:0]          vc_on_off,
    output logic [NUM_VC-1:0]          vc_allocatable,
    output logic [ADDR_WIDTH-1:0]      araddr,
    output logic                       arvalid,
    input  logic                       arready,
    output logic [ADDR_WIDTH-1:0]      awaddr,
    output logic                       awvalid,
    input  logic                       awready,
    output logic [DATA_WIDTH-1:0]      wdata,
    output logic                       wvalid,
    input  logic                       wready,
`ifdef SNA_REQ_WSTRB_EN
    output logic [DATA_WIDTH/8-1:0]    wstrb,
`endif
    output logic [NODE_ADDR_WIDTH-1:0] tag_src,
    output logic                       tag_read,
    output logic                       tag_valid,
    input  logic                       tag_pop
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_RD      = 3'd1;
    localparam logic [2:0] c_ST_WR_BOTH = 3'd2;
    localparam logic [2:0] c_ST_WR_W    = 3'd3;
    localparam logic [2:0] c_ST_WR_AW   = 3'd4;

    logic [2:0] r_state;
    logic [2:0] w_state_next;

    // ------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0]      r_req_addr_mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]      r_req_data_mem [FIFO_DEPTH];
    logic                       r_req_read_mem [FIFO_DEPTH];
    logic [NODE_ADDR_WIDTH-1:0] r_req_src_mem  [FIFO_DEPTH];
    logic [c_PTR_W:0]           r_req_wr_ptr;
    logic [c_PTR_W:0]           r_req_rd_ptr;
    logic [c_PTR_W-1:0]         w_req_wr_idx;
    logic [c_PTR_W-1:0]         w_req_rd_idx;
    logic                       w_req_full;
    logic                       w_req_empty;
    logic                       w_req_push;
    logic                       w_req_pop;
    logic                       w_head_read;

    // ------------------------------------------------------------------
    // Tag FIFO
    // ------------------------------------------------------------------
    logic [NODE_ADDR_WIDTH-1:0] r_tag_src_mem  [FIFO_DEPTH];
    logic                       r_tag_read_mem [FIFO_DEPTH];
    logic [c_PTR_W:0]           r_tag_wr_ptr;
    logic [c_PTR_W:0]           r_tag_rd_ptr;
    logic [c_PTR_W-1:0]         w_tag_wr_idx;
    logic [c_PTR_W-1:0]         w_tag_rd_idx;
    logic                       w_tag_full;
    logic                       w_tag_empty;
    logic                       w_tag_push;
    logic                       w_tag_push_read;
    logic                       w_tag_wr_en;
    logic                       w_tag_rd_en;

    // Issue registers: hold the in-flight request stable for the AXI side
    logic [ADDR_WIDTH-1:0]      r_iss_addr;
    logic [DATA_WIDTH-1:0]      r_iss_data;
    logic [NODE_ADDR_WIDTH-1:0] r_iss_src;

    assign w_req_wr_idx = r_req_wr_ptr[c_PTR_W-1:0];
    assign w_req_rd_idx = r_req_rd_ptr[c_PTR_W-1:0];
    assign w_req_empty  = (r_req_wr_ptr == r_req_rd_ptr);
    assign w_req_full   = (r_req_wr_ptr[c_PTR_W] != r_req_rd_ptr[c_PTR_W]) &&
                          (w_req_wr_idx == w_req_rd_idx);
    assign w_req_push   = req_valid && !w_req_full;
    assign w_req_pop    = (r_state == c_ST_IDLE) && !w_req_empty && !w_tag_full;
    assign w_head_read  = r_req_read_mem[w_req_rd_idx];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_req_wr_ptr <= '0;
            r_req_rd_ptr <= '0;
        end else begin
            if (w_req_push) begin
                r_req_wr_ptr <= r_req_wr_ptr + 1'b1;
            end
            if (w_req_pop) begin
                r_req_rd_ptr <= r_req_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_req_push) begin
            r_req_addr_mem[w_req_wr_idx] <= req_addr;
            r_req_data_mem[w_req_wr_idx] <= req_data;
            r_req_read_mem[w_req_wr_idx] <= req_read;
            r_req_src_mem[w_req_wr_idx]  <= req_src;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_iss_addr <= '0;
            r_iss_data <= '0;
            r_iss_src  <= '0;
        end else if (w_req_pop) begin
            r_iss_addr <= r_req_addr_mem[w_req_rd_idx];
            r_iss_data <= r_req_data_mem[w_req_rd_idx];
            r_iss_src  <= r_req_src_mem[w_req_rd_idx];
        end
    end

`ifdef SNA_REQ_WSTRB_EN
    logic [DATA_WIDTH/8-1:0] r_req_strb_mem [FIFO_DEPTH];
    logic [DATA_WIDTH/8-1:0] r_iss_strb;

    always_ff @(posedge clock) begin
        if (w_req_push) begin
            r_req_strb_mem[w_req_wr_idx] <= req_strb;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_iss_strb <= '0;
        end else if (w_req_pop) begin
            r_iss_strb <= r_req_strb_mem[w_req_rd_idx];
        end
    end

    assign wstrb = r_iss_strb;
`else
    // No strobe storage: every write is a full-word write at the slave.
`endif

    // ------------------------------------------------------------------
    // Issue FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_req_pop) begin
                    w_state_next = w_head_read ? c_ST_RD : c_ST_WR_BOTH;
                end
            end
            c_ST_RD: begin
                if (arready) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            c_ST_WR_BOTH: begin
                if (awready && wready) begin
                    w_state_next = c_ST_IDLE;
                end else if (awready) begin
                    w_state_next = c_ST_WR_W;
                end else if (wready) begin
                    w_state_next = c_ST_WR_AW;
                end
            end
            c_ST_WR_W: begin
                if (wready) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            c_ST_WR_AW: begin
                if (awready) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        arvalid         = 1'b0;
        awvalid         = 1'b0;
        wvalid          = 1'b0;
        w_tag_push      = 1'b0;
        w_tag_push_read = 1'b0;
        case (r_state)
            c_ST_RD: begin
                arvalid         = 1'b1;
                w_tag_push      = arready;
                w_tag_push_read = 1'b1;
            end
            c_ST_WR_BOTH: begin
                awvalid    = 1'b1;
                wvalid     = 1'b1;
                w_tag_push = awready && wready;
            end
            c_ST_WR_W: begin
                wvalid     = 1'b1;
                w_tag_push = wready;
            end
            c_ST_WR_AW: begin
                awvalid    = 1'b1;
                w_tag_push = awready;
            end
            default: begin
                arvalid = 1'b0;
            end
        endcase
    end

    assign araddr = r_iss_addr;
    assign awaddr = r_iss_addr;
    assign wdata  = r_iss_data;

    // ------------------------------------------------------------------
    // Tag FIFO: a push while full is accepted only alongside a pop
    // ------------------------------------------------------------------
    assign w_tag_wr_idx = r_tag_wr_ptr[c_PTR_W-1:0];
    assign w_tag_rd_idx = r_tag_rd_ptr[c_PTR_W-1:0];
    assign w_tag_empty  = (r_tag_wr_ptr == r_tag_rd_ptr);
    assign w_tag_full   = (r_tag_wr_ptr[c_PTR_W] != r_tag_rd_ptr[c_PTR_W]) &&
                          (w_tag_wr_idx == w_tag_rd_idx);
    assign w_tag_rd_en  = tag_pop && !w_tag_empty;
    assign w_tag_wr_en  = w_tag_push && (!w_tag_full || w_tag_rd_en);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_tag_wr_ptr <= '0;
            r_tag_rd_ptr <= '0;
        end else begin
            if (w_tag_wr_en) begin
                r_tag_wr_ptr <= r_tag_wr_ptr + 1'b1;
            end
            if (w_tag_rd_en) begin
                r_tag_rd_ptr <= r_tag_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_tag_wr_en) begin
            r_tag_src_mem[w_tag_wr_idx]  <= r_iss_src;
            r_tag_read_mem[w_tag_wr_idx] <= w_tag_push_read;
        end
    end

    assign tag_valid = !w_tag_empty;
    assign tag_src   = w_tag_empty ? '0   : r_tag_src_mem[w_tag_rd_idx];
    assign tag_read  = w_tag_empty ? 1'b0 : r_tag_read_mem[w_tag_rd_idx];

    // ------------------------------------------------------------------
    // NoC flow control
    // ------------------------------------------------------------------
    assign vc_on_off      = {NUM_VC{!w_req_full}};
    assign vc_allocatable = {NUM_VC{w_req_empty && (r_state == c_ST_IDLE)}};

endmodule
`default_nettype wire

// File: tb/tb_sna_axi_request_issuer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sna_axi_request_issuer
// Brief    : Scoreboard bench for sna_axi_request_issuer (honours
//            SNA_REQ_WSTRB_EN when defined).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sna_axi_request_issuer;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NW = 4;
    localparam int NV = 8;
    localparam int DEPTH = 4;
    localparam int SW = DW / 8;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_data = '0;
    logic          req_read = 1'b0;
    logic [NW-1:0] req_src = '0;
    logic          req_valid = 1'b0;
    logic [NV-1:0] vc_on_off, vc_allocatable;
    logic [AW-1:0] araddr, awaddr;
    logic          arvalid, awvalid, wvalid;
    logic          arready = 1'b0, awready = 1'b0, wready = 1'b0;
    logic [DW-1:0] wdata;
    logic [NW-1:0] tag_src;
    logic          tag_read, tag_valid;
    logic          tag_pop = 1'b0;
`ifdef SNA_REQ_WSTRB_EN
    logic [SW-1:0] req_strb = '1;
    logic [SW-1:0] wstrb;
`endif

    typedef struct packed { logic [DW-1:0] data; logic [SW-1:0] strb; } wexp_t;
    typedef struct packed { logic [NW-1:0] src; logic rd; } tag_t;

    logic [AW-1:0] exp_ar[$];
    logic [AW-1:0] exp_aw[$];
    wexp_t         exp_w[$];
    tag_t          exp_tag[$];
    int vectors = 0;
    int errors = 0;

    always #5 clock = ~clock;

    sna_axi_request_issuer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NODE_ADDR_WIDTH(NW),
        .NUM_VC(NV), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .req_addr(req_addr), .req_data(req_data), .req_read(req_read),
        .req_src(req_src), .req_valid(req_valid),
`ifdef SNA_REQ_WSTRB_EN
        .req_strb(req_strb),
`endif
        .vc_on_off(vc_on_off), .vc_allocatable(vc_allocatable),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wvalid(wvalid), .wready(wready),
`ifdef SNA_REQ_WSTRB_EN
        .wstrb(wstrb),
`endif
        .tag_src(tag_src), .tag_read(tag_read), .tag_valid(tag_valid),
        .tag_pop(tag_pop)
    );

    // Handshake monitor: pops scoreboard entries and checks valid/payload hold.
    logic          p_ar = 1'b0, p_aw = 1'b0, p_w = 1'b0;
    logic [AW-1:0] p_araddr, p_awaddr;
    logic [DW-1:0] p_wdata;
    always @(negedge clock) begin
        logic [AW-1:0] ea;
        wexp_t         ew;
        tag_t          et;
        if (!reset_n) begin
            p_ar = 1'b0; p_aw = 1'b0; p_w = 1'b0;
        end else begin
            if (p_ar) begin
                vectors++;
                if (arvalid !== 1'b1 || araddr !== p_araddr) begin
                    errors++; $display("FAIL ar_hold: arvalid=%b araddr=%h required 1/%h", arvalid, araddr, p_araddr);
                end
            end
            if (p_aw) begin
                vectors++;
                if (awvalid !== 1'b1 || awaddr !== p_awaddr) begin
                    errors++; $display("FAIL aw_hold: awvalid=%b awaddr=%h required 1/%h", awvalid, awaddr, p_awaddr);
                end
            end
            if (p_w) begin
                vectors++;
                if (wvalid !== 1'b1 || wdata !== p_wdata) begin
                    errors++; $display("FAIL w_hold: wvalid=%b wdata=%h required 1/%h", wvalid, wdata, p_wdata);
                end
            end
            if (arvalid && arready) begin
                vectors++;
                if (exp_ar.size() == 0) begin
                    errors++; $display("FAIL ar_unexpected: araddr=%h required no AR", araddr);
                end else begin
                    ea = exp_ar.pop_front();
                    if (araddr !== ea) begin errors++; $display("FAIL ar_addr: araddr=%h required %h", araddr, ea); end
                end
            end
            if (awvalid && awready) begin
                vectors++;
                if (exp_aw.size() == 0) begin
                    errors++; $display("FAIL aw_unexpected: awaddr=%h required no AW", awaddr);
                end else begin
                    ea = exp_aw.pop_front();
                    if (awaddr !== ea) begin errors++; $display("FAIL aw_addr: awaddr=%h required %h", awaddr, ea); end
                end
            end
            if (wvalid && wready) begin
                vectors++;
                if (exp_w.size() == 0) begin
                    errors++; $display("FAIL w_unexpected: wdata=%h required no W", wdata);
                end else begin
                    ew = exp_w.pop_front();
                    if (wdata !== ew.data) begin errors++; $display("FAIL w_data: wdata=%h required %h", wdata, ew.data); end
`ifdef SNA_REQ_WSTRB_EN
                    if (wstrb !== ew.strb) begin errors++; $display("FAIL w_strb: wstrb=%b required %b", wstrb, ew.strb); end
`endif
                end
            end
            if (tag_valid && tag_pop) begin
                vectors++;
                if (exp_tag.size() == 0) begin
                    errors++; $display("FAIL tag_unexpected: tag_src=%h required no tag", tag_src);
                end else begin
                    et = exp_tag.pop_front();
                    if (tag_src !== et.src || tag_read !== et.rd) begin
                        errors++; $display("FAIL tag_entry: src=%h read=%b required %h/%b", tag_src, tag_read, et.src, et.rd);
                    end
                end
            end
            p_ar = arvalid && !arready; p_araddr = araddr;
            p_aw = awvalid && !awready; p_awaddr = awaddr;
            p_w  = wvalid && !wready;   p_wdata  = wdata;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_req(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic rd,
                             input logic [NW-1:0] s, input logic [SW-1:0] st, input bit accept);
        wexp_t ew;
        req_addr = a; req_data = d; req_read = rd; req_src = s; req_valid = 1'b1;
`ifdef SNA_REQ_WSTRB_EN
        req_strb = st;
`endif
        if (accept) begin
            if (rd) begin
                exp_ar.push_back(a);
            end else begin
                ew.data = d; ew.strb = st;
                exp_aw.push_back(a);
                exp_w.push_back(ew);
            end
            exp_tag.push_back({s, rd});
        end
    endtask

    task automatic idle_req();
        req_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int c = 0;
        while ((exp_ar.size() + exp_aw.size() + exp_w.size() + exp_tag.size()) != 0 && c < budget) begin
            tick(); c++;
        end
        repeat (4) tick();
        vectors++;
        if (c >= budget) begin
            errors++; $display("FAIL %s_drain: %0d entries left after %0d cycles required 0", name,
                               exp_ar.size() + exp_aw.size() + exp_w.size() + exp_tag.size(), budget);
        end
        exp_ar.delete(); exp_aw.delete(); exp_w.delete(); exp_tag.delete();
    endtask

    task automatic test_reset();
        #2;
        vectors++; if ({arvalid, awvalid, wvalid} !== 3'b000) begin errors++; $display("FAIL rst_valids: %b required 000", {arvalid, awvalid, wvalid}); end
        vectors++; if (araddr !== '0 || awaddr !== '0) begin errors++; $display("FAIL rst_addr: %h/%h required 0", araddr, awaddr); end
        vectors++; if (wdata !== '0) begin errors++; $display("FAIL rst_wdata: %h required 0", wdata); end
        vectors++; if ({tag_valid, tag_read} !== 2'b00 || tag_src !== '0) begin errors++; $display("FAIL rst_tag: v=%b r=%b s=%h required 0", tag_valid, tag_read, tag_src); end
        vectors++; if (vc_on_off !== 8'hFF) begin errors++; $display("FAIL rst_vc_on_off: %h required ff", vc_on_off); end
        vectors++; if (vc_allocatable !== 8'hFF) begin errors++; $display("FAIL rst_vc_alloc: %h required ff", vc_allocatable); end
`ifdef SNA_REQ_WSTRB_EN
        vectors++; if (wstrb !== '0) begin errors++; $display("FAIL rst_wstrb: %b required 0", wstrb); end
`endif
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        arready = 1'b1;
        drive_req(32'h5555_5555, '0, 1'b1, 4'b0101, '1, 1'b1);
        tick(); idle_req();
        vectors++; if (arvalid !== 1'b0) begin errors++; $display("FAIL rd_early: arvalid=%b required 0", arvalid); end
        tick();
        vectors++; if (arvalid !== 1'b1 || araddr !== 32'h5555_5555) begin errors++; $display("FAIL rd_issue: arvalid=%b araddr=%h required 1/55555555", arvalid, araddr); end
        tick();
        vectors++; if (arvalid !== 1'b0) begin errors++; $display("FAIL rd_one_cycle: arvalid=%b required 0", arvalid); end
        vectors++; if (tag_valid !== 1'b1 || tag_src !== 4'd5 || tag_read !== 1'b1) begin errors++; $display("FAIL rd_tag: v=%b s=%h r=%b required 1/5/1", tag_valid, tag_src, tag_read); end
        vectors++; if (vc_allocatable !== 8'hFF) begin errors++; $display("FAIL rd_alloc: %h required ff", vc_allocatable); end
        tag_pop = 1'b1; tick(); tag_pop = 1'b0;
        vectors++; if (tag_valid !== 1'b0) begin errors++; $display("FAIL rd_tag_pop: tag_valid=%b required 0", tag_valid); end
        arready = 1'b0;
    endtask

    task automatic test_write_w_first();
        awready = 1'b0; wready = 1'b1;
        drive_req(32'hA5A5_0000, 32'hFFFF_FFFF, 1'b0, 4'h3, '1, 1'b1);
        tick(); idle_req(); tick();
        vectors++; if ({awvalid, wvalid} !== 2'b11 || wdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wr_issue: aw/w=%b wdata=%h required 11/ffffffff", {awvalid, wvalid}, wdata); end
        tick();
        vectors++; if ({awvalid, wvalid} !== 2'b10) begin errors++; $display("FAIL wr_w_done: aw/w=%b required 10", {awvalid, wvalid}); end
        vectors++; if (vc_allocatable !== 8'h00) begin errors++; $display("FAIL wr_alloc: %h required 00", vc_allocatable); end
        tick(); tick();
        vectors++; if (awvalid !== 1'b1 || tag_valid !== 1'b0) begin errors++; $display("FAIL wr_aw_wait: awvalid=%b tag_valid=%b required 1/0", awvalid, tag_valid); end
        awready = 1'b1; tick(); awready = 1'b0;
        vectors++; if (awvalid !== 1'b0 || tag_valid !== 1'b1 || tag_src !== 4'h3 || tag_read !== 1'b0) begin errors++; $display("FAIL wr_tag: aw=%b v=%b s=%h r=%b required 0/1/3/0", awvalid, tag_valid, tag_src, tag_read); end
        tag_pop = 1'b1; tick(); tag_pop = 1'b0; wready = 1'b0;
    endtask

    task automatic test_fill();
        arready = 1'b0; tag_pop = 1'b0;
        drive_req(32'h0000_1000, '0, 1'b1, 4'h1, '1, 1'b1);
        tick();
        for (int i = 0; i < DEPTH + 1; i++) begin
            drive_req(32'h0000_2000 + 32'(i * 4), '0, 1'b1, 4'(i + 2), '1, i < DEPTH);
            tick();
            if (i == DEPTH - 2) begin
                vectors++; if (vc_on_off !== 8'hFF) begin errors++; $display("FAIL fill_not_full: vc_on_off=%h required ff", vc_on_off); end
            end
            if (i >= DEPTH - 1) begin
                vectors++; if (vc_on_off !== 8'h00) begin errors++; $display("FAIL fill_full_%0d: vc_on_off=%h required 00", i, vc_on_off); end
            end
        end
        idle_req();
        vectors++; if (vc_allocatable !== 8'h00) begin errors++; $display("FAIL fill_alloc: %h required 00", vc_allocatable); end
        arready = 1'b1; tag_pop = 1'b1;
        wait_drain(80, "fill");
        vectors++; if (vc_on_off !== 8'hFF || tag_valid !== 1'b0) begin errors++; $display("FAIL fill_after: vc=%h tag_valid=%b required ff/0", vc_on_off, tag_valid); end
        arready = 1'b0; tag_pop = 1'b0;
    endtask

    task automatic test_tag_full();
        bit seen = 1'b0;
        arready = 1'b1; tag_pop = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            drive_req(32'h0000_3000 + 32'(i * 4), '0, 1'b1, 4'(i + 6), '1, 1'b1);
            tick();
        end
        idle_req();
        repeat (16) tick();
        vectors++; if (arvalid !== 1'b0) begin errors++; $display("FAIL tagfull_stall: arvalid=%b required 0", arvalid); end
        vectors++; if (tag_valid !== 1'b1 || tag_src !== 4'h6) begin errors++; $display("FAIL tagfull_head: v=%b s=%h required 1/6", tag_valid, tag_src); end
        vectors++; if (vc_allocatable !== 8'h00) begin errors++; $display("FAIL tagfull_alloc: %h required 00", vc_allocatable); end
        tag_pop = 1'b1; tick(); tag_pop = 1'b0;
        for (int c = 0; c < 4 && !seen; c++) begin
            if (arvalid === 1'b1) seen = 1'b1;
            else tick();
        end
        vectors++; if (!seen) begin errors++; $display("FAIL tagfull_resume: arvalid=%b required 1 within 4 cycles", arvalid); end
        tag_pop = 1'b1;
        wait_drain(60, "tagfull");
        arready = 1'b0; tag_pop = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        awready = 1'b0; wready = 1'b0;
        drive_req(32'h0000_4000, 32'h1234_5678, 1'b0, 4'h9, '1, 1'b1);
        tick();
        drive_req(32'h0000_4004, 32'h8765_4321, 1'b0, 4'hA, '1, 1'b1);
        tick(); idle_req();
        vectors++; if ({awvalid, wvalid} !== 2'b11 || vc_allocatable !== 8'h00) begin errors++; $display("FAIL rstmid_pre: aw/w=%b alloc=%h required 11/00", {awvalid, wvalid}, vc_allocatable); end
        #2 reset_n = 1'b0;
        #1;
        vectors++; if ({arvalid, awvalid, wvalid} !== 3'b000) begin errors++; $display("FAIL rstmid_valids: %b required 000", {arvalid, awvalid, wvalid}); end
        vectors++; if (vc_allocatable !== 8'hFF || vc_on_off !== 8'hFF) begin errors++; $display("FAIL rstmid_vc: alloc=%h on=%h required ff/ff", vc_allocatable, vc_on_off); end
        vectors++; if (tag_valid !== 1'b0) begin errors++; $display("FAIL rstmid_tag: tag_valid=%b required 0", tag_valid); end
        exp_ar.delete(); exp_aw.delete(); exp_w.delete(); exp_tag.delete();
        tick(); tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        tag_pop = 1'b1;
        for (int r = 0; r < 3; r++) begin
            int c = 0;
            while (c < 300 && (c < DEPTH ||
                   (exp_ar.size() + exp_aw.size() + exp_w.size() + exp_tag.size()) != 0)) begin
                arready = 1'($urandom_range(0, 1));
                awready = 1'($urandom_range(0, 1));
                wready  = 1'($urandom_range(0, 1));
                if (c < DEPTH) drive_req($urandom, $urandom, 1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 1'b1);
                else idle_req();
                tick(); c++;
            end
            idle_req();
            vectors++; if (c >= 300) begin errors++; $display("FAIL b2b_round%0d: timeout with %0d tags left required 0", r, exp_tag.size()); end
            arready = 1'b0; awready = 1'b0; wready = 1'b0;
            repeat (4) tick();
            exp_ar.delete(); exp_aw.delete(); exp_w.delete(); exp_tag.delete();
        end
        tag_pop = 1'b0;
    endtask

`ifdef SNA_REQ_WSTRB_EN
    task automatic test_wstrb();
        awready = 1'b0; wready = 1'b0; tag_pop = 1'b1;
        drive_req(32'h0000_5000, 32'hCAFE_F00D, 1'b0, 4'h2, 4'b0011, 1'b1);
        tick(); idle_req(); tick();
        vectors++; if (wvalid !== 1'b1 || wstrb !== 4'b0011) begin errors++; $display("FAIL wstrb_drive: wvalid=%b wstrb=%b required 1/0011", wvalid, wstrb); end
        awready = 1'b1; wready = 1'b1;
        wait_drain(20, "wstrb");
        awready = 1'b0; wready = 1'b0; tag_pop = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_read();
        test_write_w_first();
        test_fill();
        test_tag_full();
        test_reset_mid_write();
        test_back_to_back();
`ifdef SNA_REQ_WSTRB_EN
        test_wstrb();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
